// File: rtl/alu_stream_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : alu_stream_wrapper
//  Description : Streaming ALU. Accepts a three-word input frame
//                (CTRL, A, B), executes one of eight ALU operations and
//                returns the result (and, optionally, a flags word) as an
//                output frame. Counts completed output frames.
//  Config      : `define ALU_STREAM_FLAGS_EN to append the flags word
//                {overflow, negative, zero, borrow, carry} after the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_stream_wrapper #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_NOT = 3'd5;
    localparam logic [2:0] c_OP_SHL = 3'd6;
    localparam logic [2:0] c_OP_SHR = 3'd7;

`ifdef ALU_STREAM_FLAGS_EN
    // One extra bit keeps the carry/borrow out of the adder and subtractor
    localparam int c_SUM_W = DATA_W + 1;

    typedef enum logic [2:0] {
        S_CTRL    = 3'd0,
        S_GET_A   = 3'd1,
        S_GET_B   = 3'd2,
        S_EXEC    = 3'd3,
        S_OUT_RES = 3'd4,
        S_OUT_FLG = 3'd5
    } state_t;
`else
    localparam int c_SUM_W = DATA_W;

    typedef enum logic [2:0] {
        S_CTRL    = 3'd0,
        S_GET_A   = 3'd1,
        S_GET_B   = 3'd2,
        S_EXEC    = 3'd3,
        S_OUT_RES = 3'd4
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_en;
    logic [2:0]          r_op;
    logic                r_cin;
    logic                r_bin;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_res;
    logic [DATA_W-1:0]   w_res;
    logic [c_SUM_W-1:0]  w_add;
    logic [c_SUM_W-1:0]  w_sub;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic                w_in_fire;
    logic                w_frame_done;
`ifdef ALU_STREAM_FLAGS_EN
    logic [4:0]          r_flg;
    logic [4:0]          w_flg;
    logic                w_carry;
    logic                w_borrow;
    logic                w_ovf;
`endif

    // in_ready is gated by r_in_en so it stays low during reset and only
    // rises on the first clock edge after reset is released
    assign in_ready     = r_in_en && ((r_state == S_CTRL) ||
                                      (r_state == S_GET_A) ||
                                      (r_state == S_GET_B));
    assign w_in_fire    = in_valid && in_ready;
    assign w_frame_done = out_valid && out_ready && out_last;
    assign busy         = (r_state != S_CTRL);
    assign frame_cnt    = r_frame_cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CTRL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input-enable: low in reset, high from the first edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_en <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
        end
    end

    // Next-state and output-stream decode
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (r_state)
            S_CTRL: begin
                if (w_in_fire) w_state_nxt = S_GET_A;
            end
            S_GET_A: begin
                if (w_in_fire) w_state_nxt = S_GET_B;
            end
            S_GET_B: begin
                if (w_in_fire) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_OUT_RES;
            end
            S_OUT_RES: begin
                out_valid = 1'b1;
                out_data  = r_res;
`ifdef ALU_STREAM_FLAGS_EN
                if (out_ready) w_state_nxt = S_OUT_FLG;
`else
                out_last  = 1'b1;
                if (out_ready) w_state_nxt = S_CTRL;
`endif
            end
`ifdef ALU_STREAM_FLAGS_EN
            S_OUT_FLG: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = {{(DATA_W-5){1'b0}}, r_flg};
                if (out_ready) w_state_nxt = S_CTRL;
            end
`endif
            default: begin
                w_state_nxt = S_CTRL;
            end
        endcase
    end

    // Capture the CTRL fields and operands as each input word transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op  <= '0;
            r_cin <= 1'b0;
            r_bin <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_in_fire) begin
            case (r_state)
                S_CTRL: begin
                    r_op  <= in_data[2:0];
                    r_cin <= in_data[3];
                    r_bin <= in_data[4];
                end
                S_GET_A: r_a <= in_data;
                S_GET_B: r_b <= in_data;
                default: ;
            endcase
        end
    end

    // Datapath result for the captured opcode, modulo 2^DATA_W
    always_comb begin
        w_add = c_SUM_W'(r_a) + c_SUM_W'(r_b) + c_SUM_W'(r_cin);
        w_sub = c_SUM_W'(r_a) - c_SUM_W'(r_b) - c_SUM_W'(r_bin);
        w_res = '0;
        case (r_op)
            c_OP_ADD: w_res = w_add[DATA_W-1:0];
            c_OP_SUB: w_res = w_sub[DATA_W-1:0];
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_NOT: w_res = ~r_a;
            c_OP_SHL: w_res = {r_a[DATA_W-2:0], 1'b0};
            c_OP_SHR: w_res = {1'b0, r_a[DATA_W-1:1]};
            default:  w_res = '0;
        endcase
    end

`ifdef ALU_STREAM_FLAGS_EN
    // Status flags; carry doubles as the bit shifted out for SHL/SHR
    always_comb begin
        w_carry  = 1'b0;
        w_borrow = 1'b0;
        w_ovf    = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_carry = w_add[DATA_W];
                w_ovf   = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                          (w_res[DATA_W-1] != r_a[DATA_W-1]);
            end
            c_OP_SUB: begin
                w_borrow = w_sub[DATA_W];
                w_ovf    = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                           (w_res[DATA_W-1] != r_a[DATA_W-1]);
            end
            c_OP_SHL: w_carry = r_a[DATA_W-1];
            c_OP_SHR: w_carry = r_a[0];
            default:  ;
        endcase
        w_flg = {w_ovf, w_res[DATA_W-1], (w_res == '0), w_borrow, w_carry};
    end
`endif

    // Register the ALU outcome in S_EXEC so the output words stay stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res <= '0;
`ifdef ALU_STREAM_FLAGS_EN
            r_flg <= '0;
`endif
        end else if (r_state == S_EXEC) begin
            r_res <= w_res;
`ifdef ALU_STREAM_FLAGS_EN
            r_flg <= w_flg;
`endif
        end
    end

    // Completed-frame counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_stream_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_stream_wrapper
//  Description : Directed self-checking bench for alu_stream_wrapper.
//                Frame counter is narrowed to 3 bits so wrap is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stream_wrapper;

    localparam int c_DW = 8;
    localparam int c_CW = 3;

    logic            clk;
    logic            rst;
    logic [c_DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [c_DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic [c_CW-1:0] frame_cnt;

    int              n_chk  = 0;
    int              n_pass = 0;
    logic [c_CW-1:0] exp_cnt = '0;

    alu_stream_wrapper #(.DATA_W(c_DW), .CNT_W(c_CW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_word(input logic [c_DW-1:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic recv_word(input string tag, input logic [c_DW-1:0] d, input logic last);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
        @(posedge clk); #1;
    endtask

    // Full frame with out_ready held high; checks latency, words and counter
    task automatic run_frame(input string tag, input logic [7:0] ctrl, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] res, input logic [7:0] flg);
        send_word(ctrl);
        send_word(a);
        send_word(b);
        chk({tag, "_exec_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_exec_busy"},  {31'd0, busy},      32'd1);
        @(posedge clk); #1;
        chk({tag, "_lat_valid"},  {31'd0, out_valid}, 32'd1);
`ifdef ALU_STREAM_FLAGS_EN
        recv_word({tag, "_res"}, res, 1'b0);
        recv_word({tag, "_flg"}, flg, 1'b1);
`else
        recv_word({tag, "_res"}, res, 1'b1);
        if (flg === 8'hxx) $display("note: flags word not produced in this build");
`endif
        exp_cnt = exp_cnt + 1'b1;
        chk({tag, "_cnt"},      {29'd0, frame_cnt}, {29'd0, exp_cnt});
        chk({tag, "_rdy_next"}, {31'd0, in_ready},  32'd1);
        chk({tag, "_idle"},     {31'd0, busy},      32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state, with one clock edge seen while held
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_cnt",       {29'd0, frame_cnt}, 32'd0);
        #10;
        rst = 1'b1;
        #1;
        chk("rel_rdy_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_rdy_high", {31'd0, in_ready}, 32'd1);

        // Arithmetic frames
        run_frame("add_ovf",  8'h00, 8'h7F, 8'h01, 8'h80, 8'h18);
        run_frame("sub_brw",  8'h01, 8'h00, 8'h01, 8'hFF, 8'h0A);
        run_frame("add_cin",  8'h08, 8'hFE, 8'h01, 8'h00, 8'h05);

        // Back-pressure: output held, input ignored, then released
        out_ready = 1'b0;
        send_word(8'h00);
        send_word(8'h7F);
        send_word(8'h01);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data",  {24'd0, out_data},  32'h80);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_rdy",   {31'd0, in_ready},  32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_STREAM_FLAGS_EN
        recv_word("stall_res", 8'h80, 1'b0);
        recv_word("stall_flg", 8'h18, 1'b1);
`else
        recv_word("stall_res", 8'h80, 1'b1);
`endif
        exp_cnt = exp_cnt + 1'b1;
        chk("stall_cnt", {29'd0, frame_cnt}, {29'd0, exp_cnt});

        // Remaining opcodes; the fourth frame here wraps the 3-bit counter
        run_frame("and",     8'h02, 8'hCC, 8'hAA, 8'h88, 8'h08);
        run_frame("or",      8'h03, 8'h0F, 8'h30, 8'h3F, 8'h00);
        run_frame("not",     8'h05, 8'hFF, 8'h00, 8'h00, 8'h04);
        run_frame("shr",     8'h07, 8'h81, 8'h00, 8'h40, 8'h01);
        run_frame("shl",     8'h06, 8'h81, 8'h00, 8'h02, 8'h01);
        run_frame("sub_ovf", 8'h01, 8'h80, 8'h01, 8'h7F, 8'h10);
        run_frame("sub_bin", 8'h11, 8'h05, 8'h02, 8'h02, 8'h00);
        run_frame("ctrl_hi", 8'hE0, 8'h01, 8'h02, 8'h03, 8'h00);

        // Reset during the output phase
        out_ready = 1'b0;
        send_word(8'h00);
        send_word(8'h01);
        send_word(8'h01);
        @(posedge clk); #1;
        chk("orst_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        exp_cnt = '0;
        chk("orst_valid", {31'd0, out_valid}, 32'd0);
        chk("orst_data",  {24'd0, out_data},  32'd0);
        chk("orst_busy",  {31'd0, busy},      32'd0);
        chk("orst_cnt",   {29'd0, frame_cnt}, 32'd0);
        #2;
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("orst_rdy", {31'd0, in_ready}, 32'd1);

        // Reset after A accepted, then a clean frame
        send_word(8'h00);
        send_word(8'h7F);
        rst = 1'b0;
        #1;
        chk("irst_rdy",   {31'd0, in_ready},  32'd0);
        chk("irst_busy",  {31'd0, busy},      32'd0);
        chk("irst_valid", {31'd0, out_valid}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("irst_rdy_rel", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("irst_rdy_edge", {31'd0, in_ready}, 32'd1);
        run_frame("xor", 8'h04, 8'hF0, 8'hFF, 8'h0F, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
